// File: rtl/accel_pkg.sv
// Shared encodings and width helpers for the accelerometer sample conditioner.
package accel_pkg;
    typedef enum logic [1:0] {
        MODE_SINGLE     = 2'd0,
        MODE_SUM        = 2'd1,
        MODE_INTERLEAVE = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_e;

    // Select and index widths are never allowed to collapse to zero bits.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition of i_level.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_pulse
);
    logic hist_q;
    logic pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            hist_q  <= i_level;
            pulse_q <= i_level & ~hist_q;
        end
    end

    assign o_pulse = pulse_q;
endmodule

// File: rtl/accel_sample_conditioner.sv
// Averages/decimates NUM_CH axis samples by 2^k and emits one axis, the axis sum,
// or all axes interleaved as a left-justified strobe stream for the FFT.
module accel_sample_conditioner
    import accel_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int IN_W         = 8,
    parameter int OUT_W        = 16,
    parameter int AVG_LOG2_MAX = 3
) (
    input  logic                           sys_clock,
    input  logic                           reset_n,
    input  logic                           i_en,
    input  logic                           i_sync,
    input  logic [NUM_CH*IN_W-1:0]         i_data,
    input  logic [1:0]                     i_mode,
    input  logic [ch_w(NUM_CH)-1:0]        i_ch,
    input  logic [ch_w(AVG_LOG2_MAX+1)-1:0] i_avg_log2,
    output logic                           o_valid,
    output logic [OUT_W-1:0]               o_data,
    output logic [ch_w(NUM_CH)-1:0]        o_ch,
    output logic                           o_overrun
);
    localparam int CH_W    = ch_w(NUM_CH);
    localparam int K_W     = ch_w(AVG_LOG2_MAX+1);
    localparam int ACC_W   = IN_W + AVG_LOG2_MAX;
    localparam int CNT_W   = AVG_LOG2_MAX + 1;
    localparam int SAT_W   = IN_W + 2;
    localparam int SAT_MAX = (1 << (SAT_W-1)) - 1;
    localparam int SAT_MIN = -(1 << (SAT_W-1));

    logic [NUM_CH*IN_W-1:0] data_q;
    logic                   evt;
    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d;
    logic [CH_W-1:0]        ch_q, ch_d, idx_q, idx_d, och_q, och_d;
    logic [K_W-1:0]         k_q, k_d, k_cl;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc, target;
    logic                   vld_q, vld_d, ovr_q, ovr_d;
    logic [OUT_W-1:0]       dout_q, dout_d;
    logic                   acc_clr, acc_add;
    logic signed [ACC_W-1:0] acc_q [NUM_CH];
    logic signed [IN_W-1:0]  avg   [NUM_CH];
    logic signed [SAT_W-1:0] sat;
    int                      sum;

    function automatic logic [OUT_W-1:0] lj(input logic signed [IN_W-1:0] v);
        return OUT_W'(v) << (OUT_W - IN_W);
    endfunction

    sync_edge_detect u_sync_edge (
        .clk     (sys_clock),
        .rst_n   (reset_n),
        .i_level (i_sync),
        .o_pulse (evt)
    );

    // Samples are captured alongside the edge so the registered pulse sees the event-time data.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) data_q <= '0;
        else          data_q <= i_data;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_acc
        logic signed [IN_W-1:0]  smp;
        logic signed [ACC_W-1:0] shr;
        assign smp = signed'(data_q[c*IN_W +: IN_W]);
        assign shr = acc_q[c] >>> k_q;
        assign avg[c] = shr[IN_W-1:0];

        always_ff @(posedge sys_clock or negedge reset_n) begin
            if (!reset_n)     acc_q[c] <= '0;
            else if (acc_clr) acc_q[c] <= '0;
            else if (acc_add) acc_q[c] <= acc_q[c] + ACC_W'(smp);
        end
    end

    always_comb begin
        sum = 0;
        for (int c = 0; c < NUM_CH; c++) sum = sum + int'(avg[c]);
        if (sum > SAT_MAX)      sat = SAT_W'(SAT_MAX);
        else if (sum < SAT_MIN) sat = SAT_W'(SAT_MIN);
        else                    sat = SAT_W'(sum);
    end

    assign k_cl    = (int'(i_avg_log2) > AVG_LOG2_MAX) ? K_W'(AVG_LOG2_MAX) : i_avg_log2;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign target  = CNT_W'(1) << k_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ch_d    = ch_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        vld_d   = 1'b0;
        dout_d  = dout_q;
        och_d   = och_q;
        ovr_d   = ovr_q;
        acc_clr = 1'b0;
        acc_add = 1'b0;
        if (!i_en) begin
            state_d = IDLE;
            acc_clr = 1'b1;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: if (evt) begin
                    unique case (i_mode)
                        2'd1:    mode_d = MODE_SUM;
                        2'd2:    mode_d = MODE_INTERLEAVE;
                        default: mode_d = MODE_SINGLE;
                    endcase
                    ch_d    = (int'(i_ch) >= NUM_CH) ? '0 : i_ch;
                    k_d     = k_cl;
                    acc_add = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = (k_cl == '0) ? EMIT : ACCUM;
                end
                ACCUM: if (evt) begin
                    acc_add = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == target) state_d = EMIT;
                end
                EMIT: begin
                    if (evt) ovr_d = 1'b1;
                    vld_d = 1'b1;
                    unique case (mode_q)
                        MODE_SUM: begin
                            dout_d = OUT_W'(sat) << (OUT_W - SAT_W);
                            och_d  = '0;
                        end
                        MODE_INTERLEAVE: begin
                            dout_d = lj(avg[idx_q]);
                            och_d  = idx_q;
                        end
                        default: begin
                            dout_d = lj(avg[ch_q]);
                            och_d  = ch_q;
                        end
                    endcase
                    if (mode_q != MODE_INTERLEAVE || int'(idx_q) == NUM_CH-1) begin
                        state_d = IDLE;
                        acc_clr = 1'b1;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + CH_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_SINGLE;
            ch_q    <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            dout_q  <= '0;
            och_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ch_q    <= ch_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            dout_q  <= dout_d;
            och_q   <= och_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_valid   = vld_q;
    assign o_data    = dout_q;
    assign o_ch      = och_q;
    assign o_overrun = ovr_q;
endmodule
